// File: rtl/xfer_pkg.sv
// rtl/xfer_pkg.sv - shared op encodings and sequencer state enum for xfer_seq
package xfer_pkg;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/xfer_onehot_bar.sv
// rtl/xfer_onehot_bar.sv - index plus enable to active-low one-hot; out-of-range index gives all-ones
module xfer_onehot_bar #(
    parameter int NREG = 4,
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            i_en,
    input  logic [IW-1:0]   i_idx,
    output logic [NREG-1:0] o_bar
);

    always_comb begin
        o_bar = '1;
        for (int i = 0; i < NREG; i++) begin
            o_bar[i] = !(i_en && (i_idx == IW'(i)));
        end
    end

endmodule

// File: rtl/xfer_seq.sv
// rtl/xfer_seq.sv - register-transfer sequencer driving bus enables and LOAD strobes
// Optional OP=10 clear transfer is enabled by defining XFER_SEQ_CLEAR_EN.
module xfer_seq
    import xfer_pkg::*;
#(
    parameter int NREG          = 4,
    parameter int SETTLE_CYCLES = 1,
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            REQ,
    input  logic [1:0]      OP,
    input  logic [IW-1:0]   SRC_A,
    input  logic [IW-1:0]   SRC_B,
    input  logic [IW-1:0]   DST,
    output logic            BUSY,
    output logic            DONE,
    output logic [NREG-1:0] LOAD,
    output logic [NREG-1:0] CLEAR_bar,
    output logic [NREG-1:0] ASSERT_MAIN_bar,
    output logic [NREG-1:0] ASSERT_LHS_bar,
    output logic [NREG-1:0] ASSERT_RHS_bar,
    output logic            ALU_ASSERT_bar
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    xfer_state_e   r_state;
    xfer_state_e   w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_op;
    logic [IW-1:0] r_src_a;
    logic [IW-1:0] r_src_b;
    logic [IW-1:0] r_dst;

    logic            w_drive;
    logic            w_op_loads;
    logic [NREG-1:0] w_load_bar;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (REQ) w_next = ST_SETTLE;
            ST_SETTLE: if (r_cnt == CW'(SETTLE_CYCLES - 1)) w_next = ST_STROBE;
            ST_STROBE: w_next = ST_HOLD;
            ST_HOLD:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Request fields are captured only on acceptance so the enables stay stable for the whole transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_op    <= OP_RSVD;
            r_src_a <= '0;
            r_src_b <= '0;
            r_dst   <= '0;
        end else if (r_state == ST_IDLE && REQ) begin
            r_cnt   <= '0;
            r_op    <= OP;
            r_src_a <= SRC_A;
            r_src_b <= SRC_B;
            r_dst   <= DST;
        end else if (r_state == ST_SETTLE) begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign w_drive        = (r_state != ST_IDLE);
    assign BUSY           = w_drive;
    assign DONE           = (r_state == ST_HOLD);
    assign ALU_ASSERT_bar = !(w_drive && r_op == OP_ALU);

`ifdef XFER_SEQ_CLEAR_EN
    assign w_op_loads = (r_op != OP_RSVD);

    xfer_onehot_bar #(.NREG(NREG)) u_clear (
        .i_en  (w_drive && r_op == OP_CLEAR),
        .i_idx (r_dst),
        .o_bar (CLEAR_bar)
    );
`else
    assign w_op_loads = (r_op != OP_RSVD) && (r_op != OP_CLEAR);
    assign CLEAR_bar  = '1;
`endif

    xfer_onehot_bar #(.NREG(NREG)) u_main (
        .i_en  (w_drive && r_op == OP_MOVE),
        .i_idx (r_src_a),
        .o_bar (ASSERT_MAIN_bar)
    );

    xfer_onehot_bar #(.NREG(NREG)) u_lhs (
        .i_en  (w_drive && r_op == OP_ALU),
        .i_idx (r_src_a),
        .o_bar (ASSERT_LHS_bar)
    );

    xfer_onehot_bar #(.NREG(NREG)) u_rhs (
        .i_en  (w_drive && r_op == OP_ALU),
        .i_idx (r_src_b),
        .o_bar (ASSERT_RHS_bar)
    );

    xfer_onehot_bar #(.NREG(NREG)) u_load (
        .i_en  ((r_state == ST_STROBE) && w_op_loads),
        .i_idx (r_dst),
        .o_bar (w_load_bar)
    );

    assign LOAD = ~w_load_bar;

endmodule

// File: tb/tb_xfer_seq.sv
// tb/tb_xfer_seq.sv - directed self-checking bench for xfer_seq (S=1 and S=2 instances)
module tb_xfer_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] op;
    logic [1:0] src_a, src_b, dst;

    logic       busy, done, alu_bar;
    logic [3:0] load, clr_bar, main_bar, lhs_bar, rhs_bar;
    logic       busy2, done2, alu_bar2;
    logic [3:0] load2, clr_bar2, main_bar2, lhs_bar2, rhs_bar2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xfer_seq #(.NREG(4), .SETTLE_CYCLES(1)) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .OP(op),
        .SRC_A(src_a), .SRC_B(src_b), .DST(dst),
        .BUSY(busy), .DONE(done), .LOAD(load), .CLEAR_bar(clr_bar),
        .ASSERT_MAIN_bar(main_bar), .ASSERT_LHS_bar(lhs_bar),
        .ASSERT_RHS_bar(rhs_bar), .ALU_ASSERT_bar(alu_bar)
    );

    xfer_seq #(.NREG(4), .SETTLE_CYCLES(2)) dut2 (
        .CLK(clk), .RESET(rst), .REQ(req), .OP(op),
        .SRC_A(src_a), .SRC_B(src_b), .DST(dst),
        .BUSY(busy2), .DONE(done2), .LOAD(load2), .CLEAR_bar(clr_bar2),
        .ASSERT_MAIN_bar(main_bar2), .ASSERT_LHS_bar(lhs_bar2),
        .ASSERT_RHS_bar(rhs_bar2), .ALU_ASSERT_bar(alu_bar2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; op = 2'b00; src_a = 0; src_b = 0; dst = 0;
        repeat (2) cyc();
        checks++; if (main_bar !== 4'b1111) begin failures++; $display("FAIL reset_main got %b exp 1111", main_bar); end
        checks++; if (lhs_bar !== 4'b1111) begin failures++; $display("FAIL reset_lhs got %b exp 1111", lhs_bar); end
        checks++; if (rhs_bar !== 4'b1111) begin failures++; $display("FAIL reset_rhs got %b exp 1111", rhs_bar); end
        checks++; if (clr_bar !== 4'b1111) begin failures++; $display("FAIL reset_clear got %b exp 1111", clr_bar); end
        checks++; if (alu_bar !== 1'b1) begin failures++; $display("FAIL reset_alu got %b exp 1", alu_bar); end
        checks++; if (load !== 4'b0000) begin failures++; $display("FAIL reset_load got %b exp 0000", load); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        rst = 1'b0;
    endtask

    task automatic test_move();
        do_reset();
        op = 2'b00; src_a = 2'd2; src_b = 2'd0; dst = 2'd1; req = 1'b1;
        cyc();
        req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (main_bar !== ((c <= 3) ? 4'b1011 : 4'b1111)) begin failures++; $display("FAIL move_main cycle %0d got %b", c, main_bar); end
            checks++; if (load !== ((c == 2) ? 4'b0010 : 4'b0000)) begin failures++; $display("FAIL move_load cycle %0d got %b", c, load); end
            checks++; if (done !== (c == 3)) begin failures++; $display("FAIL move_done cycle %0d got %b", c, done); end
            checks++; if (busy !== (c <= 3)) begin failures++; $display("FAIL move_busy cycle %0d got %b", c, busy); end
            checks++; if (alu_bar !== 1'b1 || lhs_bar !== 4'b1111) begin failures++; $display("FAIL move_alu_lhs cycle %0d got %b %b", c, alu_bar, lhs_bar); end
            if (c < 4) cyc();
        end
    endtask

    task automatic test_alu();
        do_reset();
        op = 2'b01; src_a = 2'd0; src_b = 2'd3; dst = 2'd2; req = 1'b1;
        cyc();
        req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++; if (lhs_bar2 !== ((c <= 4) ? 4'b1110 : 4'b1111)) begin failures++; $display("FAIL alu_lhs cycle %0d got %b", c, lhs_bar2); end
            checks++; if (rhs_bar2 !== ((c <= 4) ? 4'b0111 : 4'b1111)) begin failures++; $display("FAIL alu_rhs cycle %0d got %b", c, rhs_bar2); end
            checks++; if (alu_bar2 !== !(c <= 4)) begin failures++; $display("FAIL alu_assert cycle %0d got %b", c, alu_bar2); end
            checks++; if (load2 !== ((c == 3) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL alu_load cycle %0d got %b", c, load2); end
            checks++; if (done2 !== (c == 4)) begin failures++; $display("FAIL alu_done cycle %0d got %b", c, done2); end
            checks++; if (main_bar2 !== 4'b1111) begin failures++; $display("FAIL alu_main cycle %0d got %b exp 1111", c, main_bar2); end
            if (c < 5) cyc();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        op = 2'b00; src_a = 2'd1; src_b = 2'd0; dst = 2'd0; req = 1'b1;
        cyc();
        for (int c = 1; c <= 9; c++) begin
            checks++; if (done !== (c == 3 || c == 7)) begin failures++; $display("FAIL b2b_done cycle %0d got %b", c, done); end
            checks++; if (busy !== !(c == 4 || c == 8)) begin failures++; $display("FAIL b2b_busy cycle %0d got %b", c, busy); end
            checks++; if (load !== ((c == 2 || c == 6) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL b2b_load cycle %0d got %b", c, load); end
            if (c < 9) cyc();
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        op = 2'b00; src_a = 2'd3; src_b = 2'd0; dst = 2'd2; req = 1'b1;
        cyc();
        req = 1'b0;
        cyc();
        checks++; if (load !== 4'b0100) begin failures++; $display("FAIL rmid_load_c2 got %b exp 0100", load); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_done_busy got %b%b exp 00", done, busy); end
        checks++; if (main_bar !== 4'b1111 || load !== 4'b0000) begin failures++; $display("FAIL rmid_outputs got %b %b exp 1111 0000", main_bar, load); end
        cyc();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmid_late_done got %b exp 0", done); end
    endtask

    task automatic test_clear();
        logic [3:0] exp_clr;
        logic [3:0] exp_load;
        do_reset();
        op = 2'b10; src_a = 2'd0; src_b = 2'd0; dst = 2'd3; req = 1'b1;
        cyc();
        req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
`ifdef XFER_SEQ_CLEAR_EN
            exp_clr  = (c <= 3) ? 4'b0111 : 4'b1111;
            exp_load = (c == 2) ? 4'b1000 : 4'b0000;
`else
            exp_clr  = 4'b1111;
            exp_load = 4'b0000;
`endif
            checks++; if (clr_bar !== exp_clr) begin failures++; $display("FAIL clear_bar cycle %0d got %b exp %b", c, clr_bar, exp_clr); end
            checks++; if (load !== exp_load) begin failures++; $display("FAIL clear_load cycle %0d got %b exp %b", c, load, exp_load); end
            checks++; if (done !== (c == 3)) begin failures++; $display("FAIL clear_done cycle %0d got %b", c, done); end
            checks++; if (main_bar !== 4'b1111 || alu_bar !== 1'b1) begin failures++; $display("FAIL clear_bus cycle %0d got %b %b", c, main_bar, alu_bar); end
            if (c < 4) cyc();
        end
    endtask

    task automatic test_rsvd();
        do_reset();
        op = 2'b11; src_a = 2'd1; src_b = 2'd2; dst = 2'd3; req = 1'b1;
        cyc();
        req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (load !== 4'b0000 || main_bar !== 4'b1111 || lhs_bar !== 4'b1111 || rhs_bar !== 4'b1111 || alu_bar !== 1'b1) begin
                failures++; $display("FAIL rsvd_strobes cycle %0d got load %b main %b lhs %b rhs %b alu %b", c, load, main_bar, lhs_bar, rhs_bar, alu_bar);
            end
            checks++; if (done !== (c == 3)) begin failures++; $display("FAIL rsvd_done cycle %0d got %b", c, done); end
            if (c < 4) cyc();
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_alu();
        test_back_to_back();
        test_reset_mid();
        test_clear();
        test_rsvd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
